// File: rtl/march_response_analyzer_if.sv
// Bus bundle between the March generator side and the response analyzer.
// Carries the generator operation bus, SRAM read data and the analyzer status.
interface march_response_analyzer_if #(
    parameter int unsigned ADDR_WIDTH     = 8,
    parameter int unsigned DATA_WIDTH     = 4,
    parameter int unsigned PATTERN_WIDTH  = 2,
    parameter int unsigned FAIL_CNT_WIDTH = 9
);
    logic                                  cen;
    logic [ADDR_WIDTH+PATTERN_WIDTH:0]     gen_bus;
    logic                                  gen_done;
    logic [DATA_WIDTH-1:0]                 rdata;
    logic                                  busy;
    logic                                  done;
    logic                                  pass;
    logic                                  fail;
    logic [FAIL_CNT_WIDTH-1:0]             fail_count;
    logic [ADDR_WIDTH-1:0]                 first_fail_addr;
    logic [DATA_WIDTH-1:0]                 first_fail_data;
    logic [DATA_WIDTH-1:0]                 first_fail_exp;

    modport master (
        output cen, gen_bus, gen_done, rdata,
        input  busy, done, pass, fail, fail_count,
        input  first_fail_addr, first_fail_data, first_fail_exp
    );

    modport slave (
        input  cen, gen_bus, gen_done, rdata,
        output busy, done, pass, fail, fail_count,
        output first_fail_addr, first_fail_data, first_fail_exp
    );
endinterface

// File: rtl/march_response_analyzer.sv
// March BIST response analyzer: derives the expected word for each read on the
// generator bus, delays it by READ_LATENCY and compares it with SRAM rdata.
// Optional first-failure capture is built only when MARCH_FAIL_LOG_EN is defined.
module march_response_analyzer #(
    parameter int unsigned ADDR_WIDTH     = 8,
    parameter int unsigned DATA_WIDTH     = 4,
    parameter int unsigned PATTERN_WIDTH  = 2,
    parameter int unsigned READ_LATENCY   = 1,
    parameter int unsigned FAIL_CNT_WIDTH = 9
) (
    input logic                     clk,
    input logic                     rst,
    march_response_analyzer_if.slave bus
);
    localparam int unsigned BusWidth = ADDR_WIDTH + PATTERN_WIDTH + 1;

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e state_q, state_d;
    logic [2:0] drain_cnt_q, drain_cnt_d;

    logic                     we;
    logic [31:0]              code_ext;
    logic [DATA_WIDTH-1:0]    exp_word;
    logic [DATA_WIDTH-1:0]    alt;
    logic                     accept;
    logic                     miscompare;

    logic                     pipe_valid_q [READ_LATENCY];
    logic [DATA_WIDTH-1:0]    pipe_exp_q   [READ_LATENCY];

    logic                     fail_q;
    logic [FAIL_CNT_WIDTH-1:0] fail_count_q;

    assign we       = bus.gen_bus[ADDR_WIDTH];
    assign code_ext = 32'(bus.gen_bus[BusWidth-1 -: PATTERN_WIDTH]);

    // Expected word from the pattern code; unknown codes map to all zeros.
    always_comb begin
        alt      = '0;
        exp_word = '0;
        for (int i = 0; i < int'(DATA_WIDTH); i++) begin
            alt[i] = i[0];
        end
        if (code_ext == 32'd1) begin
            exp_word = '1;
        end else if (code_ext == 32'd2) begin
            exp_word = alt;
        end else if (code_ext == 32'd3) begin
            exp_word = ~alt;
        end
    end

    // Reads are only launched before the drain phase starts.
    assign accept = bus.cen && !we && (state_q == StIdle || state_q == StRun);

    assign miscompare = pipe_valid_q[READ_LATENCY-1] &&
                        (bus.rdata != pipe_exp_q[READ_LATENCY-1]);

    // Expected-word pipeline lining up with the SRAM read latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(READ_LATENCY); i++) begin
                pipe_valid_q[i] <= 1'b0;
                pipe_exp_q[i]   <= '0;
            end
        end else begin
            pipe_valid_q[0] <= accept;
            pipe_exp_q[0]   <= exp_word;
            for (int i = 1; i < int'(READ_LATENCY); i++) begin
                pipe_valid_q[i] <= pipe_valid_q[i-1];
                pipe_exp_q[i]   <= pipe_exp_q[i-1];
            end
        end
    end

    // Sticky fail flag and saturating miscompare counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fail_q       <= 1'b0;
            fail_count_q <= '0;
        end else if (miscompare) begin
            fail_q <= 1'b1;
            if (fail_count_q != '1) begin
                fail_count_q <= fail_count_q + FAIL_CNT_WIDTH'(1);
            end
        end
    end

`ifdef MARCH_FAIL_LOG_EN
    logic [ADDR_WIDTH-1:0] pipe_addr_q [READ_LATENCY];
    logic [ADDR_WIDTH-1:0] ff_addr_q;
    logic [DATA_WIDTH-1:0] ff_data_q;
    logic [DATA_WIDTH-1:0] ff_exp_q;

    // Address pipeline, only needed for first-failure capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(READ_LATENCY); i++) begin
                pipe_addr_q[i] <= '0;
            end
        end else begin
            pipe_addr_q[0] <= bus.gen_bus[ADDR_WIDTH-1:0];
            for (int i = 1; i < int'(READ_LATENCY); i++) begin
                pipe_addr_q[i] <= pipe_addr_q[i-1];
            end
        end
    end

    // Capture the first miscompare; gated on the sticky fail flag still clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ff_addr_q <= '0;
            ff_data_q <= '0;
            ff_exp_q  <= '0;
        end else if (miscompare && !fail_q) begin
            ff_addr_q <= pipe_addr_q[READ_LATENCY-1];
            ff_data_q <= bus.rdata;
            ff_exp_q  <= pipe_exp_q[READ_LATENCY-1];
        end
    end

    assign bus.first_fail_addr = ff_addr_q;
    assign bus.first_fail_data = ff_data_q;
    assign bus.first_fail_exp  = ff_exp_q;
`else
    assign bus.first_fail_addr = '0;
    assign bus.first_fail_data = '0;
    assign bus.first_fail_exp  = '0;
`endif

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            drain_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    // Next state: drain holds for READ_LATENCY+1 cycles so the last compare
    // has been registered before done rises.
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (bus.gen_done) begin
                    state_d     = StDrain;
                    drain_cnt_d = '0;
                end else if (bus.cen) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (bus.gen_done) begin
                    state_d     = StDrain;
                    drain_cnt_d = '0;
                end
            end
            StDrain: begin
                if (drain_cnt_q == 3'(READ_LATENCY)) begin
                    state_d = StDone;
                end else begin
                    drain_cnt_d = drain_cnt_q + 3'd1;
                end
            end
            StDone: state_d = StDone;
            default: state_d = StIdle;
        endcase
    end

    assign bus.busy       = (state_q == StRun) || (state_q == StDrain);
    assign bus.done       = (state_q == StDone);
    assign bus.pass       = (state_q == StDone) && !fail_q;
    assign bus.fail       = fail_q;
    assign bus.fail_count = fail_count_q;
endmodule

// File: tb/tb_march_response_analyzer.sv
// Bench for march_response_analyzer: two instances (latency 1 / 9-bit counter and
// latency 3 / 3-bit counter) share one random operation stream; each gets its own
// SRAM response stream, and a transaction-level model predicts every output.
module tb_march_response_analyzer;
    localparam int unsigned AW = 8;
    localparam int unsigned DW = 4;
    localparam int unsigned PW = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int unsigned edge_n = 0;

    always #5 clk = ~clk;

    // Completed rising edges; the model keys its compares on this index.
    always @(posedge clk) edge_n <= edge_n + 1;

    march_response_analyzer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PATTERN_WIDTH(PW),
                                 .FAIL_CNT_WIDTH(9)) bus0 ();
    march_response_analyzer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PATTERN_WIDTH(PW),
                                 .FAIL_CNT_WIDTH(3)) bus1 ();

    march_response_analyzer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PATTERN_WIDTH(PW),
                              .READ_LATENCY(1), .FAIL_CNT_WIDTH(9)) u_dut0 (
        .clk(clk), .rst(rst), .bus(bus0)
    );
    march_response_analyzer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PATTERN_WIDTH(PW),
                              .READ_LATENCY(3), .FAIL_CNT_WIDTH(3)) u_dut1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int          lat  [2] = '{1, 3};
    int unsigned cmax [2] = '{511, 7};

    bit          m_accepting [2];
    bit          m_started   [2];
    bit          m_fail      [2];
    int unsigned m_cnt       [2];
    int unsigned m_done_at   [2];
    logic [7:0]  m_ffa [2];
    logic [3:0]  m_ffd [2];
    logic [3:0]  m_ffe [2];

    // Outstanding reads, indexed by the edge at which their rdata is sampled.
    bit          r_v [2][8];
    logic [7:0]  r_a [2][8];
    logic [3:0]  r_e [2][8];
    logic [3:0]  r_d [2][8];

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] pattern_word(int code);
        logic [3:0] w = 4'h0;
        for (int b = 0; b < 4; b++) begin
            case (code)
                1:       w[b] = 1'b1;
                2:       w[b] = (b % 2 == 1);
                3:       w[b] = (b % 2 == 0);
                default: w[b] = 1'b0;
            endcase
        end
        return w;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_accepting[i] = 1'b1;
            m_started[i]   = 1'b0;
            m_fail[i]      = 1'b0;
            m_cnt[i]       = 0;
            m_done_at[i]   = 0;
            m_ffa[i] = '0;
            m_ffd[i] = '0;
            m_ffe[i] = '0;
            for (int s = 0; s < 8; s++) r_v[i][s] = 1'b0;
        end
    endtask

    task automatic check_inst(int i, logic busy, logic done, logic pass, logic fail,
                              logic [31:0] cnt, logic [7:0] ffa, logic [3:0] ffd,
                              logic [3:0] ffe);
        bit done_e;
        done_e = (m_done_at[i] != 0) && (edge_n >= m_done_at[i]);
        check($sformatf("u%0d_busy@%0d", i, edge_n), 32'(busy), 32'(m_started[i] && !done_e));
        check($sformatf("u%0d_done@%0d", i, edge_n), 32'(done), 32'(done_e));
        check($sformatf("u%0d_pass@%0d", i, edge_n), 32'(pass), 32'(done_e && !m_fail[i]));
        check($sformatf("u%0d_fail@%0d", i, edge_n), 32'(fail), 32'(m_fail[i]));
        check($sformatf("u%0d_count@%0d", i, edge_n), cnt, m_cnt[i]);
`ifdef MARCH_FAIL_LOG_EN
        check($sformatf("u%0d_ffaddr@%0d", i, edge_n), 32'(ffa), 32'(m_ffa[i]));
        check($sformatf("u%0d_ffdata@%0d", i, edge_n), 32'(ffd), 32'(m_ffd[i]));
        check($sformatf("u%0d_ffexp@%0d", i, edge_n), 32'(ffe), 32'(m_ffe[i]));
`else
        check($sformatf("u%0d_ffaddr@%0d", i, edge_n), 32'(ffa), 32'd0);
        check($sformatf("u%0d_ffdata@%0d", i, edge_n), 32'(ffd), 32'd0);
        check($sformatf("u%0d_ffexp@%0d", i, edge_n), 32'(ffe), 32'd0);
`endif
    endtask

    task automatic check_all();
        check_inst(0, bus0.busy, bus0.done, bus0.pass, bus0.fail, 32'(bus0.fail_count),
                   bus0.first_fail_addr, bus0.first_fail_data, bus0.first_fail_exp);
        check_inst(1, bus1.busy, bus1.done, bus1.pass, bus1.fail, 32'(bus1.fail_count),
                   bus1.first_fail_addr, bus1.first_fail_data, bus1.first_fail_exp);
    endtask

    // One bus cycle. fault: 0 = good read data, 1 = random corruption, 2 = fdata.
    task automatic step(bit cen, bit we, logic [7:0] addr, int code, bit gdone,
                        int fault, logic [3:0] fdata);
        int unsigned e;
        int          slot;
        logic [3:0]  rd;
        logic [3:0]  ew;
        @(negedge clk);
        e = edge_n + 1;
        bus0.cen = cen;      bus1.cen = cen;
        bus0.gen_done = gdone; bus1.gen_done = gdone;
        bus0.gen_bus = {code[1:0], we, addr};
        bus1.gen_bus = {code[1:0], we, addr};
        for (int i = 0; i < 2; i++) begin
            slot = int'(e % 8);
            rd = r_v[i][slot] ? r_d[i][slot] : 4'($urandom);
            if (i == 0) bus0.rdata = rd; else bus1.rdata = rd;
            if (r_v[i][slot]) begin
                if (r_d[i][slot] != r_e[i][slot]) begin
                    if (!m_fail[i]) begin
                        m_ffa[i] = r_a[i][slot];
                        m_ffd[i] = r_d[i][slot];
                        m_ffe[i] = r_e[i][slot];
                    end
                    m_fail[i] = 1'b1;
                    if (m_cnt[i] < cmax[i]) m_cnt[i]++;
                end
                r_v[i][slot] = 1'b0;
            end
            if (m_accepting[i] && cen && !we) begin
                ew   = pattern_word(code);
                slot = int'((e + lat[i]) % 8);
                r_v[i][slot] = 1'b1;
                r_a[i][slot] = addr;
                r_e[i][slot] = ew;
                r_d[i][slot] = (fault == 0) ? ew :
                               (fault == 2) ? fdata : (ew ^ 4'($urandom_range(1, 15)));
            end
            if (!m_started[i] && (cen || gdone)) m_started[i] = 1'b1;
            if (m_accepting[i] && gdone) begin
                m_accepting[i] = 1'b0;
                m_done_at[i]   = e + lat[i] + 1;
            end
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle(int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 8'h00, 0, 1'b0, 0, 4'h0);
    endtask

    task automatic finish_run();
        step(1'b0, 1'b0, 8'h00, 0, 1'b1, 0, 4'h0);
        idle(6);
    endtask

    // Reset asserted between edges; outputs must clear before any clock edge.
    task automatic async_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        bus0.cen = 1'b0; bus1.cen = 1'b0;
        bus0.gen_done = 1'b0; bus1.gen_done = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic random_ops(int n, int fault_pct);
        bit cen;
        bit we;
        int fault;
        for (int k = 0; k < n; k++) begin
            cen   = ($urandom_range(0, 3) != 0);
            we    = $urandom_range(0, 1);
            fault = ($urandom_range(0, 99) < fault_pct) ? 1 : 0;
            step(cen, we, 8'($urandom), $urandom_range(0, 3), 1'b0, fault, 4'h0);
        end
    endtask

    initial begin
        bus0.cen = 1'b0; bus1.cen = 1'b0;
        bus0.gen_done = 1'b0; bus1.gen_done = 1'b0;
        bus0.gen_bus = '0; bus1.gen_bus = '0;
        bus0.rdata = '0; bus1.rdata = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst = 1'b0;

        // Clean run: 256 code-0 reads.
        for (int a = 0; a < 256; a++) step(1'b1, 1'b0, 8'(a), 0, 1'b0, 0, 4'h0);
        finish_run();

        // Single fault at 0x3C.
        async_reset();
        for (int a = 0; a < 5; a++) step(1'b1, 1'b0, 8'(a), 1, 1'b0, 0, 4'h0);
        step(1'b1, 1'b0, 8'h3C, 1, 1'b0, 2, 4'b1011);
        for (int a = 0; a < 5; a++) step(1'b1, 1'b0, 8'(a + 64), 2, 1'b0, 0, 4'h0);
        finish_run();

        // Writes and bubbles with garbage rdata, then with sporadic faults.
        async_reset();
        random_ops(150, 0);
        random_ops(100, 20);
        finish_run();
        // Bus activity after done is ignored.
        for (int k = 0; k < 6; k++) step(1'b1, 1'b0, 8'(k), 1, 1'b0, 1, 4'h0);

        // Saturation: 10 failing reads.
        async_reset();
        for (int k = 0; k < 10; k++) step(1'b1, 1'b0, 8'($urandom), $urandom_range(0, 3),
                                          1'b0, 1, 4'h0);
        finish_run();

        // Failing read in the same cycle as gen_done.
        async_reset();
        for (int a = 0; a < 8; a++) step(1'b1, 1'b0, 8'(a), 3, 1'b0, 0, 4'h0);
        step(1'b1, 1'b0, 8'hA5, 2, 1'b1, 1, 4'h0);
        idle(6);

        // gen_done straight from idle.
        async_reset();
        idle(2);
        finish_run();

        // Async reset mid-run with failures pending, then a clean run.
        async_reset();
        random_ops(30, 50);
        async_reset();
        for (int a = 0; a < 40; a++) step(1'b1, 1'b0, 8'(a), a % 4, 1'b0, 0, 4'h0);
        finish_run();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
